// File: rtl/xbus_arb_if.sv
// Bundled core, host and memory-side signals of the picoVersat data-memory bus.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface xbus_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic              core_sel;
    logic              core_we;
    logic [ADDR_W-1:0] core_addr;
    logic [DATA_W-1:0] core_data_to;
    logic [DATA_W-1:0] core_data_from;
    logic              core_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_to;
    logic [DATA_W-1:0] mem_data_from;

    modport slave (
        input  core_sel, core_we, core_addr, core_data_to,
        output core_data_from, core_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_ack, host_rdata,
        output mem_sel, mem_we, mem_addr, mem_data_to,
        input  mem_data_from
    );

    modport master (
        output core_sel, core_we, core_addr, core_data_to,
        input  core_data_from, core_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_ack, host_rdata,
        input  mem_sel, mem_we, mem_addr, mem_data_to,
        output mem_data_from
    );
endinterface

// File: rtl/xbus_arb.sv
// Core/host arbiter for the picoVersat data-memory bus with bounded host bursts and starvation guard.
// Optional XBUS_ARB_STATS_EN adds stall_cnt/grant_cnt statistics outputs.
module xbus_arb #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 12,
    parameter int MAX_BURST  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    xbus_arb_if.slave  bus
`ifdef XBUS_ARB_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] grant_cnt
`endif
);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        S_CORE = 1'b0,
        S_HOST = 1'b1
    } state_t;

    state_t            state_q;
    logic [BW-1:0]     burst_cnt_q;
    logic [SW-1:0]     starve_cnt_q;
    logic              host_ack_q;
    logic [DATA_W-1:0] host_rdata_q;

    logic              starved;
    logic              burst_last;
    logic              host_win;

    logic              sel_mux;
    logic              we_mux;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    assign starved    = (starve_cnt_q == SW'(STARVE_MAX));
    assign burst_last = (burst_cnt_q == BW'(MAX_BURST - 1));
    assign host_win   = (state_q == S_CORE) & bus.host_req & (~bus.core_sel | starved);

    // A reset landing in a host cycle suppresses that access so no write escapes.
    always_comb begin
        sel_mux   = bus.core_sel;
        we_mux    = bus.core_we;
        addr_mux  = bus.core_addr;
        wdata_mux = bus.core_data_to;
        if (state_q == S_HOST) begin
            sel_mux   = bus.host_req & ~rst;
            we_mux    = bus.host_req & bus.host_we & ~rst;
            addr_mux  = bus.host_addr;
            wdata_mux = bus.host_wdata;
        end
    end

    assign bus.mem_sel        = sel_mux;
    assign bus.mem_we         = we_mux;
    assign bus.mem_addr       = addr_mux;
    assign bus.mem_data_to    = wdata_mux;
    assign bus.core_data_from = bus.mem_data_from;
    assign bus.core_stall     = bus.core_sel & (state_q == S_HOST);
    assign bus.host_gnt       = (state_q == S_HOST);
    assign bus.host_ack       = host_ack_q;
    assign bus.host_rdata     = host_rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_CORE;
            burst_cnt_q  <= '0;
            starve_cnt_q <= '0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            case (state_q)
                S_CORE: begin
                    host_ack_q <= 1'b0;
                    if (host_win) begin
                        state_q      <= S_HOST;
                        starve_cnt_q <= '0;
                        burst_cnt_q  <= '0;
                    end else if (bus.host_req) begin
                        if (!starved) begin
                            starve_cnt_q <= starve_cnt_q + SW'(1);
                        end
                    end else begin
                        starve_cnt_q <= '0;
                    end
                end
                S_HOST: begin
                    host_ack_q <= bus.host_req;
                    if (bus.host_req) begin
                        burst_cnt_q <= burst_cnt_q + BW'(1);
                        if (!bus.host_we) begin
                            host_rdata_q <= bus.mem_data_from;
                        end
                        if (burst_last) begin
                            state_q <= S_CORE;
                        end
                    end else begin
                        state_q <= S_CORE;
                    end
                end
                default: state_q <= S_CORE;
            endcase
        end
    end

`ifdef XBUS_ARB_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] grant_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            grant_cnt_q <= '0;
        end else begin
            if (bus.core_stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (host_win) begin
                grant_cnt_q <= grant_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign grant_cnt = grant_cnt_q;
`endif
endmodule

// File: doc/xbus_arb.md
Name: xbus_arb

Overview:
- Arbiter and sequencer for the picoVersat data-memory bus.
- Shares the single-cycle bus (sel/we/addr/data_to/data_from) between the core controller and one external host/DMA master.
- The core owns the bus by default; the host gets bounded bursts.
- The core is stalled while the host owns the bus, and a starvation counter guarantees host progress under continuous core traffic.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 12, data address width.
- MAX_BURST, 4, maximum host accesses per grant (>=1).
- STARVE_MAX, 8, consecutive blocked host-request cycles before the core is forcibly stalled (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- core_sel  in  1  core access request.
- core_we  in  1  core write.
- core_addr  in  ADDR_W  core address.
- core_data_to  in  DATA_W  core write data.
- core_data_from  out  DATA_W  read data to core (combinational from mem_data_from).
- core_stall  out  1  core must hold its request and PC this cycle.
- host_req  in  1  host access request; must stay high until its access completes.
- host_we  in  1  host write.
- host_addr  in  ADDR_W  host address.
- host_wdata  in  DATA_W  host write data.
- host_gnt  out  1  host owns bus this cycle; the presented access is performed.
- host_ack  out  1  registered; one-cycle pulse after each performed host access.
- host_rdata  out  DATA_W  registered read data, valid with host_ack.
- mem_sel  out  1  bus select to memory.
- mem_we  out  1  bus write enable to memory.
- mem_addr  out  ADDR_W  bus address to memory.
- mem_data_to  out  DATA_W  bus write data to memory.
- mem_data_from  in  DATA_W  combinational read data from memory.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst is synchronous and active-high, sampled on the rising edge.
  - Reset values: state=S_CORE, burst_cnt=0, starve_cnt=0, host_ack=0, host_rdata=0.
- Reset mid-burst: aborts the grant. There is no ack for the access in that cycle, and the state returns to S_CORE.
- Bus mux: combinational on state.
  - S_CORE: mem_* driven from core_*.
  - S_HOST: mem_sel=host_req, mem_we=host_req&host_we, mem_addr=host_addr, mem_data_to=host_wdata.
  - core_data_from=mem_data_from always.
- core_stall = core_sel & (state==S_HOST). host_gnt = (state==S_HOST).
- S_CORE:
  - If host_req & core_sel: starve_cnt increments (saturates at STARVE_MAX).
  - If !host_req: starve_cnt clears.
  - Next state is S_HOST when host_req & (!core_sel | starve_cnt==STARVE_MAX). On entry, starve_cnt and burst_cnt clear.
  - The host's first access occurs in the first S_HOST cycle, so grant latency is 1 cycle after the decision.
- S_HOST:
  - Every cycle with host_req=1 performs one access and increments burst_cnt.
  - host_ack <= 1 next cycle. host_rdata <= mem_data_from when !host_we; host_rdata holds its value on writes.
  - Next state is S_CORE when !host_req, or when host_req and burst_cnt==MAX_BURST-1 (the last burst access). Otherwise stay in S_HOST.
  - After burst exhaustion, S_CORE is held for at least one cycle before a new grant, even if core_sel=0 (fairness bubble).
- host_ack is 0 in every cycle not following a performed host access.
- Core requests issued while in S_CORE are never stalled. A stalled core request completes in the first S_CORE cycle.
- Simultaneous first-time core_sel and host_req with starve_cnt<STARVE_MAX: the core wins.
- Write data and address are never registered. All memory accesses remain single-cycle.

Optional Feature:
- Macro: XBUS_ARB_STATS_EN.
- Defined:
  - Adds output stall_cnt [15:0]: the count of cycles with core_stall=1, saturating at 16'hFFFF.
  - Adds output grant_cnt [15:0]: the count of S_CORE->S_HOST transitions, wrapping.
  - Both clear on rst.
- Undefined: both ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Idle host, core writes 0x1234 to addr 0x010 then reads it:
  - mem_* mirrors core_* in the same cycle, and core_data_from=0x1234.
  - core_stall=0 and host_gnt=0 throughout.
- Core idle, host_req held 6 cycles reading addrs 0x20..0x25 (MAX_BURST=4):
  - host_gnt is high for 4 cycles, then low for 1 cycle, then high for 2 cycles.
  - host_ack pulses 6 times with data matching memory, each one cycle after its access.
- core_sel=1 continuously, host_req raised at cycle 0 (STARVE_MAX=8):
  - starve_cnt reaches 8 and S_HOST is entered.
  - core_stall=1 for exactly 4 cycles, then the core resumes with no request lost.
- Simultaneous core_sel and host_req with starve_cnt=0:
  - The core access is performed, host_gnt=0, and starve_cnt=1 next cycle.
- rst asserted in the 2nd burst cycle:
  - The next cycle shows state=S_CORE, host_ack=0, host_rdata=0, and counters at 0.
  - No memory write is issued in the reset cycle.
- With XBUS_ARB_STATS_EN, after the starvation scenario: stall_cnt=4 and grant_cnt=1.
